// File: rtl/int_stim_pkg.sv
// rtl/int_stim_pkg.sv - shared encodings for the interrupt stimulus controller
package int_stim_pkg;

  typedef enum logic [1:0] {
    DIS   = 2'd0,
    ARMED = 2'd1,
    PEND  = 2'd2,
    DONE  = 2'd3
  } ch_state_e;

  localparam logic CFG_SEL_TARGET = 1'b0;
  localparam logic CFG_SEL_CTRL   = 1'b1;

  localparam int EN_BIT   = 0;
  localparam int MODE_BIT = 1;
  localparam int MAXF_LSB = 8;
  localparam int MAXF_MSB = 15;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_PULSE = 1'b1;

  localparam logic [31:0] ACK_BASE_DEFAULT = 32'h0000_7F20;

endpackage

// File: rtl/int_stim_channel.sv
// rtl/int_stim_channel.sv - one interrupt stimulus channel: FSM, fire counter, ack timeout
// The ack-timeout counter exists only when INT_STIM_TIMEOUT_EN is defined.
module int_stim_channel
  import int_stim_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  input  logic        ack_i,
  input  logic        tgt_we_i,
  input  logic        ctrl_we_i,
  input  logic [31:0] wdata_i,
  output logic        int_o,
  output logic [7:0]  fire_cnt_o,
  output logic        timeout_err_o
);

  ch_state_e   state_q, state_d;
  logic [31:0] target_q, target_d;
  logic        mode_q, mode_d;
  logic [7:0]  maxf_q, maxf_d;
  logic        away_q, away_d;
  logic        int_q, int_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        pc_hit, limit_hit;

  assign pc_hit    = ((pc_i & ~32'h3) == (target_q & ~32'h3));
  assign limit_hit = (maxf_q != 8'd0) && (cnt_q == maxf_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= DIS;
      target_q <= '0;
      mode_q   <= 1'b0;
      maxf_q   <= '0;
      away_q   <= 1'b1;
      int_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      mode_q   <= mode_d;
      maxf_q   <= maxf_d;
      away_q   <= away_d;
      int_q    <= int_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    mode_d   = mode_q;
    maxf_d   = maxf_q;
    away_d   = away_q;
    int_d    = int_q;
    cnt_d    = cnt_q;

    if (!pc_hit) away_d = 1'b1;

    case (state_q)
      ARMED: begin
        if (pc_hit && away_q) begin
          state_d = PEND;
          int_d   = 1'b1;
          away_d  = 1'b0;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
      end
      PEND: begin
        // cnt_q already includes this fire, so the limit test is exact
        if (mode_q == MODE_PULSE || ack_i) begin
          int_d   = 1'b0;
          state_d = limit_hit ? DONE : ARMED;
        end
      end
      default: int_d = 1'b0;
    endcase

    if (tgt_we_i) target_d = wdata_i;

    if (ctrl_we_i) begin
      mode_d = wdata_i[MODE_BIT];
      maxf_d = wdata_i[MAXF_MSB:MAXF_LSB];
      int_d  = 1'b0;
      if (wdata_i[EN_BIT]) begin
        state_d = ARMED;
        cnt_d   = '0;
        away_d  = 1'b1;
      end else begin
        state_d = DIS;
      end
    end
  end

  assign int_o      = int_q;
  assign fire_cnt_o = cnt_q;

`ifdef INT_STIM_TIMEOUT_EN
  logic [15:0] wait_q, wait_d;
  logic        terr_q, terr_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q <= '0;
      terr_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      terr_q <= terr_d;
    end
  end

  // Holding the counter at zero outside PEND gives a clean count on entry
  always_comb begin
    wait_d = wait_q;
    terr_d = terr_q;
    if (state_q != PEND) begin
      wait_d = '0;
    end else if (mode_q == MODE_LEVEL) begin
      if (wait_q != 16'hFFFF) wait_d = wait_q + 16'd1;
      if (wait_d == 16'(TIMEOUT_CYC)) terr_d = 1'b1;
    end
  end

  assign timeout_err_o = terr_q;
`else
  assign timeout_err_o = 1'b0;
`endif

endmodule

// File: rtl/int_stim_ctrl.sv
// rtl/int_stim_ctrl.sv - multi-channel PC-triggered interrupt stimulus controller
// Optional ack timeout per channel is enabled by INT_STIM_TIMEOUT_EN.
module int_stim_ctrl
  import int_stim_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter logic [31:0] ACK_BASE    = ACK_BASE_DEFAULT,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [31:0]                                   macroscopic_pc,
  input  logic [31:0]                                   m_int_addr,
  input  logic [3:0]                                    m_int_byteen,
  input  logic                                          cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic                                          cfg_sel,
  input  logic [31:0]                                   cfg_wdata,
  output logic [NUM_CH-1:0]                             int_vec,
  output logic                                          interrupt,
  output logic [8*NUM_CH-1:0]                           fire_cnt,
  output logic [NUM_CH-1:0]                             timeout_err
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic sel_k;
    logic ack_k;

    assign sel_k = cfg_we && (cfg_ch == CH_W'(k));
    assign ack_k = (|m_int_byteen) &&
                   ((m_int_addr & ~32'h3) == (ACK_BASE + 32'(4 * k)));

    int_stim_channel #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .pc_i          (macroscopic_pc),
      .ack_i         (ack_k),
      .tgt_we_i      (sel_k && (cfg_sel == CFG_SEL_TARGET)),
      .ctrl_we_i     (sel_k && (cfg_sel == CFG_SEL_CTRL)),
      .wdata_i       (cfg_wdata),
      .int_o         (int_vec[k]),
      .fire_cnt_o    (fire_cnt[8*k +: 8]),
      .timeout_err_o (timeout_err[k])
    );
  end

  assign interrupt = |int_vec;

endmodule

// File: tb/tb_int_stim_ctrl.sv
// tb/tb_int_stim_ctrl.sv - self-checking bench for int_stim_ctrl (INT_STIM_TIMEOUT_EN aware)
module tb_int_stim_ctrl;
  import int_stim_pkg::*;

  localparam int          NUM_CH  = 4;
  localparam int          TO      = 16;
  localparam logic [31:0] IDLE_PC = 32'h0000_1000;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [31:0]           macroscopic_pc = IDLE_PC;
  logic [31:0]           m_int_addr = 32'h0;
  logic [3:0]            m_int_byteen = 4'h0;
  logic                  cfg_we = 1'b0;
  logic [1:0]            cfg_ch = 2'd0;
  logic                  cfg_sel = 1'b0;
  logic [31:0]           cfg_wdata = 32'h0;
  logic [NUM_CH-1:0]     int_vec;
  logic                  interrupt;
  logic [8*NUM_CH-1:0]   fire_cnt;
  logic [NUM_CH-1:0]     timeout_err;

  int checks = 0;
  int errors = 0;
  logic [NUM_CH-1:0] exp_q[$];

  int_stim_ctrl #(
    .NUM_CH      (NUM_CH),
    .ACK_BASE    (32'h0000_7F20),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .macroscopic_pc (macroscopic_pc),
    .m_int_addr     (m_int_addr),
    .m_int_byteen   (m_int_byteen),
    .cfg_we         (cfg_we),
    .cfg_ch         (cfg_ch),
    .cfg_sel        (cfg_sel),
    .cfg_wdata      (cfg_wdata),
    .int_vec        (int_vec),
    .interrupt      (interrupt),
    .fire_cnt       (fire_cnt),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [NUM_CH-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=no-scoreboard-entry expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".vec"}, 64'(int_vec), 64'(e));
      chk({tag, ".irq"}, 64'(interrupt), 64'(|e));
    end
  endtask

  task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] addr,
                      input logic [3:0] be, input logic [NUM_CH-1:0] exp);
    macroscopic_pc = pc;
    m_int_addr     = addr;
    m_int_byteen   = be;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    m_int_byteen = 4'h0;
    sb_check(tag);
  endtask

  task automatic cfg(input string tag, input int ch, input logic sel, input logic [31:0] data,
                     input logic [NUM_CH-1:0] exp);
    cfg_we       = 1'b1;
    cfg_ch       = 2'(ch);
    cfg_sel      = sel;
    cfg_wdata    = data;
    m_int_byteen = 4'h0;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    sb_check(tag);
  endtask

  initial begin
    logic exp_t;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.vec", 64'(int_vec), 64'(0));
    chk("rst.irq", 64'(interrupt), 64'(0));
    chk("rst.cnt", 64'(fire_cnt), 64'(0));
    chk("rst.terr", 64'(timeout_err), 64'(0));
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    // ch0 level, max 1
    cfg("t1.tgt", 0, CFG_SEL_TARGET, 32'h3010, 4'b0000);
    cfg("t1.ctl", 0, CFG_SEL_CTRL, 32'h0000_0101, 4'b0000);
    step("t1.pre",   32'h3000, 32'h0, 4'h0, 4'b0000);
    step("t1.fire",  32'h3010, 32'h0, 4'h0, 4'b0001);
    step("t1.hold",  32'h3014, 32'h0, 4'h0, 4'b0001);
    step("t1.ack",   32'h3014, 32'h7F20, 4'hF, 4'b0000);
    chk("t1.cnt", 64'(fire_cnt[7:0]), 64'(1));
    step("t1.away",  32'h3000, 32'h0, 4'h0, 4'b0000);
    step("t1.done",  32'h3010, 32'h0, 4'h0, 4'b0000);
    step("t1.done2", 32'h3014, 32'h0, 4'h0, 4'b0000);

    // ch1 pulse, max 3, four loops
    cfg("t2.tgt", 1, CFG_SEL_TARGET, 32'h3020, 4'b0000);
    cfg("t2.ctl", 1, CFG_SEL_CTRL, 32'h0000_0303, 4'b0000);
    for (int lp = 0; lp < 4; lp++) begin
      for (int a = 32'h3000; a <= 32'h3024; a += 4) begin
        step($sformatf("t2.l%0d.%0h", lp, a), 32'(a), 32'h0, 4'h0,
             ((a == 32'h3020) && (lp < 3)) ? 4'b0010 : 4'b0000);
      end
      if (lp == 2) chk("t2.cnt3", 64'(fire_cnt[15:8]), 64'(3));
    end
    chk("t2.cnt_final", 64'(fire_cnt[15:8]), 64'(3));

    // ch0 and ch2 share a target
    cfg("t3.tgt0", 0, CFG_SEL_TARGET, 32'h3008, 4'b0000);
    cfg("t3.ctl0", 0, CFG_SEL_CTRL, 32'h0000_0001, 4'b0000);
    cfg("t3.tgt2", 2, CFG_SEL_TARGET, 32'h3008, 4'b0000);
    cfg("t3.ctl2", 2, CFG_SEL_CTRL, 32'h0000_0001, 4'b0000);
    step("t3.pre",    32'h3004, 32'h0, 4'h0, 4'b0000);
    step("t3.fire",   32'h3008, 32'h0, 4'h0, 4'b0101);
    step("t3.hold",   32'h300C, 32'h0, 4'h0, 4'b0101);
    step("t3.ack2",   32'h300C, 32'h7F28, 4'hF, 4'b0001);
    step("t3.unmap",  32'h300C, 32'h7F40, 4'hF, 4'b0001);
    step("t3.nobe",   32'h300C, 32'h7F20, 4'h0, 4'b0001);
    step("t3.ack0",   32'h300C, 32'h7F22, 4'b0100, 4'b0000);
    chk("t3.cnt0", 64'(fire_cnt[7:0]), 64'(1));
    chk("t3.cnt2", 64'(fire_cnt[23:16]), 64'(1));
    cfg("t3.dis2", 2, CFG_SEL_CTRL, 32'h0000_0000, 4'b0000);

    // ch0 unlimited, PC parked on target
    cfg("t4.tgt", 0, CFG_SEL_TARGET, 32'h3010, 4'b0000);
    cfg("t4.ctl", 0, CFG_SEL_CTRL, 32'h0000_0001, 4'b0000);
    step("t4.fire1", 32'h3010, 32'h0, 4'h0, 4'b0001);
    step("t4.ack1",  32'h3010, 32'h7F20, 4'hF, 4'b0000);
    for (int i = 0; i < 3; i++) step($sformatf("t4.park%0d", i), 32'h3010, 32'h0, 4'h0, 4'b0000);
    chk("t4.cnt1", 64'(fire_cnt[7:0]), 64'(1));
    step("t4.leave", 32'h3014, 32'h0, 4'h0, 4'b0000);
    step("t4.fire2", 32'h3010, 32'h0, 4'h0, 4'b0001);
    chk("t4.cnt2", 64'(fire_cnt[7:0]), 64'(2));
    step("t4.ackhit", 32'h3010, 32'h7F20, 4'hF, 4'b0000);
    step("t4.norefire", 32'h3010, 32'h0, 4'h0, 4'b0000);
    step("t4.leave2", 32'h3014, 32'h0, 4'h0, 4'b0000);
    step("t4.fire3", 32'h3010, 32'h0, 4'h0, 4'b0001);
    cfg("t4.tgtpend", 0, CFG_SEL_TARGET, 32'h3040, 4'b0001);
    step("t4.pendhit", 32'h3040, 32'h0, 4'h0, 4'b0001);
    step("t4.ack3",  32'h3044, 32'h7F20, 4'hF, 4'b0000);
    chk("t4.cnt3", 64'(fire_cnt[7:0]), 64'(3));

    // ch3 pending, async reset between edges
    cfg("t5.tgt", 3, CFG_SEL_TARGET, 32'h3030, 4'b0000);
    cfg("t5.ctl", 3, CFG_SEL_CTRL, 32'h0000_0001, 4'b0000);
    step("t5.fire", 32'h3030, 32'h0, 4'h0, 4'b1000);
    #2 reset = 1'b0;
    #1;
    chk("t5.async_vec", 64'(int_vec), 64'(0));
    chk("t5.async_irq", 64'(interrupt), 64'(0));
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t5.cnt", 64'(fire_cnt), 64'(0));
    chk("t5.terr", 64'(timeout_err), 64'(0));
    step("t5.dis3", 32'h3030, 32'h0, 4'h0, 4'b0000);
    step("t5.dis_all", 32'h0000, 32'h0, 4'h0, 4'b0000);

    // ch0 level pending without ack
    cfg("t6.tgt", 0, CFG_SEL_TARGET, 32'h3010, 4'b0000);
    cfg("t6.ctl", 0, CFG_SEL_CTRL, 32'h0000_0001, 4'b0000);
    step("t6.fire", 32'h3010, 32'h0, 4'h0, 4'b0001);
    for (int i = 1; i <= 20; i++) begin
      step($sformatf("t6.wait%0d", i), 32'h3014, 32'h0, 4'h0, 4'b0001);
`ifdef INT_STIM_TIMEOUT_EN
      exp_t = (i >= TO);
`else
      exp_t = 1'b0;
`endif
      chk($sformatf("t6.terr%0d", i), 64'(timeout_err), 64'({3'b000, exp_t}));
    end
    step("t6.ack", 32'h3014, 32'h7F20, 4'hF, 4'b0000);
    chk("t6.sticky", 64'(timeout_err), 64'({3'b000, exp_t}));

    chk("sb.empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int_stim_ctrl.md
Name: int_stim_ctrl

Overview:
Synthesisable multi-channel interrupt stimulus controller for CPU system-level benches and FPGA bring-up.
- Watches the CPU's macroscopic PC and raises per-channel interrupt requests when a programmed target PC is reached.
- Holds each request until the CPU writes that channel's acknowledge address, or drops it after one cycle in pulse mode.
- Generalises the single-shot, single-target bench interrupt to NUM_CH independent channels with programmable fire counts, modes and ack timeouts.

Parameters:
- NUM_CH, 4, number of independent interrupt channels (1..8).
- ACK_BASE, 32'h0000_7F20, word address of channel 0 acknowledge; channel k acks at ACK_BASE + 4*k.
- TIMEOUT_CYC, 1024, cycles a level request may stay pending before timeout_err sets (used only with INT_STIM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset; all state clears while low.
- macroscopic_pc  in  32  CPU architectural PC; bits [1:0] are ignored.
- m_int_addr  in  32  CPU store address toward the interrupt/ack space.
- m_int_byteen  in  4  store byte enables; any bit set marks a valid store.
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  channel selected for configuration.
- cfg_sel  in  1  0 = target_pc register, 1 = ctrl register.
- cfg_wdata  in  32  configuration data.
- int_vec  out  NUM_CH  per-channel registered interrupt request.
- interrupt  out  1  OR of int_vec, registered (same cycle as int_vec).
- fire_cnt  out  8*NUM_CH  per-channel count of fires since enable (channel k at [8k+7:8k]).
- timeout_err  out  NUM_CH  sticky per-channel ack-timeout flag.

Behaviour:
- Reset values: int_vec = 0, interrupt = 0, fire_cnt = 0, timeout_err = 0. Every channel is in DIS, target_pc = 0, ctrl = 0, away = 1.
- ctrl fields:
  - bit0 enable.
  - bit1 mode: 0 = level (hold until ack), 1 = pulse (one cycle).
  - bits[15:8] max_fires: 0 means unlimited.
  - Other bits are ignored and read as zero internally.
- pc_hit = ((macroscopic_pc & ~3) == (target_pc & ~3)).
- ack_k = (|m_int_byteen) && ((m_int_addr & ~3) == ACK_BASE + 4*k).
- away flag:
  - Sets on any cycle with !pc_hit.
  - Clears when the channel fires.
  - Ensures one fire per PC visit: a PC parked on the target never refires.
- Per-channel FSM, states DIS, ARMED, PEND, DONE:
  - DIS: on a ctrl write with enable=1 go to ARMED; fire_cnt and away reset to 0 and 1.
  - ARMED: on pc_hit && away go to PEND; int_vec[k] is 1 from the next cycle (1-cycle registered latency); fire_cnt increments (saturates at 255).
  - PEND, level mode: on ack_k clear int_vec[k] on that edge, then go to DONE if max_fires != 0 and fire_cnt == max_fires, else ARMED. pc_hit is ignored while in PEND.
  - PEND, pulse mode: leave after exactly one cycle using the same DONE/ARMED rule. ack_k is ignored.
  - DONE: int_vec[k] = 0. Leave only through a ctrl write (enable=0 goes to DIS; enable=1 re-arms with counters cleared).
- Any state: a ctrl write with enable=0 goes to DIS and clears int_vec[k] next cycle. fire_cnt holds its value; timeout_err does not clear.
- A target_pc write takes effect on the next cycle's compare. A write while in PEND does not cancel the request.
- Simultaneous ack_k and pc_hit on the same edge while in PEND: the ack is processed and the hit is not counted. The channel refires only after PC leaves and returns.
- One store can ack only one channel, because ack addresses are distinct. A store to an unmapped address has no effect.
- Two channels with the same target_pc fire on the same edge, each independently.
- Asynchronous reset low mid-request clears int_vec immediately, without waiting for a clock edge.

Optional Feature:
INT_STIM_TIMEOUT_EN
- Defined:
  - Each channel has a 16-bit wait counter that clears on entry to PEND.
  - While in level-mode PEND the counter increments each cycle.
  - When it reaches TIMEOUT_CYC, timeout_err[k] sets (sticky until reset). int_vec[k] stays asserted.
- Not defined: no counters are built, and timeout_err is tied to 0.

Decomposition:
- Package int_stim_pkg holds:
  - the state encoding (DIS, ARMED, PEND, DONE);
  - the cfg_sel codes;
  - the ctrl bit positions (EN_BIT, MODE_BIT, MAXF_LSB/MSB);
  - the default ACK_BASE.
- Sub-module int_stim_channel contains one channel's FSM, registers, counter and timeout logic. The top-level instantiates NUM_CH of them with a generate loop and ORs int_vec.

Test Plan:
- Ch0 target 0x3010, level mode, max 1, enable; PC reaches 0x3010 → int_vec[0]=1 and interrupt=1 from the next cycle. Store to 0x7F20 with byteen=4'b1111 → interrupt=0 next cycle, FSM in DONE, fire_cnt[0]=1. A later PC of 0x3010 does not refire.
- Ch1 target 0x3020, pulse mode, max 3; PC loops 0x3000..0x3024 three times → exactly three 1-cycle pulses on int_vec[1], fire_cnt=3, then DONE. A fourth loop produces no pulse.
- Ch0 and ch2 both target 0x3008 → both bits rise on the same edge. Ack 0x7F28 → only int_vec[2] clears; int_vec[0] stays 1 until 0x7F20 is stored.
- PC held at 0x3010 for 5 cycles with ch0 unlimited and ack on the 2nd cycle → a single fire, no refire. PC goes to 0x3014 and back to 0x3010 → second fire, fire_cnt=2.
- Ch3 level mode pending; reset driven low between clock edges → int_vec=0 immediately. After release, all channels are in DIS and fire_cnt=0.
- INT_STIM_TIMEOUT_EN with TIMEOUT_CYC=16; ch0 pending with no ack → timeout_err[0] sets after 16 cycles and int_vec[0] stays 1. Without the macro, timeout_err stays 0.
